ahb_hart_arbiter: RTL
=====================

# ahb_hart_arbiter

Round-robin AHB-Lite arbiter that shares one slave port (e.g. the common SRAM/tohost region) among the per-hart data masters (CPUD_M_*) of mmRISC. It captures each master's address phase into a one-entry pending slot and stalls that master's data phase. It issues the captured requests to the slave as single NONSEQ transfers and routes the slave's ready, response and read data back to the owning master.

## Interface
- MASTERS, 2, number of requesting masters (1..4; normally `HART_COUNT`)
- CLK  in  1  system clock
- RES  in  1  asynchronous active-high reset
- M_HSEL  in  MASTERS  master select, bit n = master n
- M_HTRANS  in  2*MASTERS  transfer type, [2n+1:2n]
- M_HWRITE  in  MASTERS  write flag
- M_HSIZE  in  3*MASTERS  size, [3n+2:3n]
- M_HADDR  in  32*MASTERS  address, [32n+31:32n]
- M_HWDATA  in  32*MASTERS  write data
- M_HREADY  in  MASTERS  master-side bus HREADY
- M_HREADYOUT  out  MASTERS  ready back to each master
- M_HRESP  out  MASTERS  response back to each master
- M_HRDATA  out  32  read data, broadcast to all masters
- S_HSEL, S_HTRANS(2), S_HWRITE, S_HSIZE(3), S_HADDR(32), S_HWDATA(32)  out  slave request
- S_HREADY  out  1  HREADY presented to the slave
- S_HREADYOUT  in  1  slave ready
- S_HRESP  in  1  slave response
- S_HRDATA  in  32  slave read data

## Operation
- Request n is valid when M_HSEL[n] & M_HTRANS[n][1] & M_HREADY[n] & M_HREADYOUT[n]. SEQ is treated as NONSEQ. IDLE and BUSY are ignored.
- A valid request is latched at the clock edge into pending slot n (addr, write, size). The slot is then set to PEND and M_HREADYOUT[n] drops to 0.
- Per-master states: IDLE -> PEND (captured) -> DATA (slave data phase) -> IDLE on completion.
  - At most one request per master is outstanding.
  - M_HREADYOUT[n]=0 in PEND and DATA.
  - In IDLE, M_HREADYOUT[n]=1 and M_HRESP[n]=0.
- Slave address slot is free when no slave data phase is outstanding, or when the outstanding one completes this cycle (S_HREADYOUT=1).
- When the slot is free and any slot is PEND, grant the first PEND index searching from pointer P upward modulo MASTERS.
  - Drive S_HSEL=1, S_HTRANS=NONSEQ (2'b10) and the slot's addr/write/size.
  - Next cycle the granted slot enters DATA.
  - Set P = grant+1 mod MASTERS.
- Otherwise S_HSEL=0, S_HTRANS=IDLE, and addr/write/size hold their last value.
- Data phase, owner d:
  - S_HWDATA = M_HWDATA[d]. The master holds it stable while stalled.
  - M_HREADYOUT[d] = S_HREADYOUT, M_HRESP[d] = S_HRESP.
  - S_HREADY = S_HREADYOUT. When no data phase is outstanding, S_HREADY=1.
- ERROR response: the two-cycle S_HRESP=1 sequence is forwarded verbatim to the owner. The slot returns to IDLE on the second cycle, when S_HREADYOUT=1.
- M_HRDATA = S_HRDATA, combinational.
- A master whose data phase completes may present a new request in the same cycle. It is latched as PEND at that edge.

## Timing
- Reset values:
  - All slots IDLE, P=0.
  - M_HREADYOUT all 1, M_HRESP all 0.
  - S_HSEL=0, S_HTRANS=2'b00, S_HWRITE=0, S_HSIZE=0, S_HADDR=0.
  - S_HREADY=1.
- Reset asserted mid-transfer discards all pending and data phases immediately. No completion is reported to masters.
- Uncontended latency:
  - Request seen at edge T.
  - Slave address phase in cycle T+1, slave data phase in T+2.
  - M_HREADYOUT=1 in T+2 with a zero-wait slave, i.e. one master wait state.
- Back-to-back issue: a new grant's address phase overlaps the previous data phase's completing cycle. There is no idle gap with a zero-wait slave.
- Slave wait states extend DATA. Any PEND grant waits, and the grant decision is re-evaluated each cycle until the slot is free.
- Fairness: with all masters requesting continuously, each master is granted exactly once per MASTERS grants.

## Test plan
- Single master 0 writes 0x00000001 to 0x00001000, zero-wait slave:
  - slave sees NONSEQ addr 0x00001000, HWRITE=1, HSIZE=3'b010 one cycle after the request;
  - S_HWDATA=0x00000001 in the following cycle;
  - M_HREADYOUT[0] is low for exactly one cycle.
- Masters 0 and 1 request in the same cycle, P=0:
  - master 0 is granted first, then master 1 back-to-back;
  - P ends at 0;
  - M_HREADYOUT[1] is low for 2 cycles.
- Both masters requesting continuously for 8 transfers -> grants alternate 0,1,0,1,…, with exactly 4 grants each.
- Slave inserts 3 wait states on a read returning 0xDEADBEEF:
  - owner's M_HREADYOUT is low for 4 cycles;
  - the other master's pending request is held until the completing cycle;
  - M_HRDATA=0xDEADBEEF when ready=1.
- Slave ERROR response -> owner sees HRESP=1 with HREADYOUT=0, then HRESP=1 with HREADYOUT=1; the slot returns to IDLE.
- RES asserted during a PEND+DATA pair -> all outputs return to reset values asynchronously; the first request after release is granted to master 0.

Source files
------------

// File: rtl/ahb_hart_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_hart_arbiter: round-robin AHB-Lite arbiter, MASTERS masters -> 1 slave |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ahb_hart_arbiter #(
    parameter int MASTERS = 2
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic [MASTERS-1:0]    M_HSEL,
    input  logic [2*MASTERS-1:0]  M_HTRANS,
    input  logic [MASTERS-1:0]    M_HWRITE,
    input  logic [3*MASTERS-1:0]  M_HSIZE,
    input  logic [32*MASTERS-1:0] M_HADDR,
    input  logic [32*MASTERS-1:0] M_HWDATA,
    input  logic [MASTERS-1:0]    M_HREADY,
    output logic [MASTERS-1:0]    M_HREADYOUT,
    output logic [MASTERS-1:0]    M_HRESP,
    output logic [31:0]           M_HRDATA,
    output logic                  S_HSEL,
    output logic [1:0]            S_HTRANS,
    output logic                  S_HWRITE,
    output logic [2:0]            S_HSIZE,
    output logic [31:0]           S_HADDR,
    output logic [31:0]           S_HWDATA,
    output logic                  S_HREADY,
    input  logic                  S_HREADYOUT,
    input  logic                  S_HRESP,
    input  logic [31:0]           S_HRDATA
);

    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_PEND = 2'd1,
        SLOT_DATA = 2'd2
    } slot_state_t;

    slot_state_t   slot_st    [MASTERS];
    logic [31:0]   slot_addr  [MASTERS];
    logic          slot_write [MASTERS];
    logic [2:0]    slot_size  [MASTERS];

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      data_owner;
    logic               data_busy;
    logic [31:0]        last_addr;
    logic               last_write;
    logic [2:0]         last_size;

    logic [MASTERS-1:0] req_vld;
    logic [MASTERS-1:0] pend_vec;
    logic               pend_found;
    logic [IW-1:0]      grant_idx;
    logic               slot_free;
    logic               grant_vld;
    logic [31:0]        grant_addr;
    logic               grant_write;
    logic [2:0]         grant_size;
    logic [IW-1:0]      next_ptr;
    logic               unused_htrans;

    // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY, neither of which matters here
    assign unused_htrans = ^M_HTRANS;

    always_comb begin
        M_HREADYOUT = '1;
        M_HRESP     = '0;
        pend_vec    = '0;
        for (int n = 0; n < MASTERS; n++) begin
            case (slot_st[n])
                SLOT_PEND: M_HREADYOUT[n] = 1'b0;
                SLOT_DATA: begin
                    M_HREADYOUT[n] = S_HREADYOUT;
                    M_HRESP[n]     = S_HRESP;
                end
                default: ;
            endcase
            pend_vec[n] = (slot_st[n] == SLOT_PEND);
        end
    end

    always_comb begin
        req_vld = '0;
        for (int n = 0; n < MASTERS; n++) begin
            req_vld[n] = M_HSEL[n] & M_HTRANS[2*n+1] & M_HREADY[n] & M_HREADYOUT[n];
        end
    end

    // Round-robin: first pending index at or above the pointer, else wrap to the bottom
    always_comb begin
        pend_found = 1'b0;
        grant_idx  = '0;
        for (int n = 0; n < MASTERS; n++) begin
            if (!pend_found && pend_vec[n] && (n >= int'(rr_ptr))) begin
                pend_found = 1'b1;
                grant_idx  = IW'(n);
            end
        end
        for (int n = 0; n < MASTERS; n++) begin
            if (!pend_found && pend_vec[n] && (n < int'(rr_ptr))) begin
                pend_found = 1'b1;
                grant_idx  = IW'(n);
            end
        end
    end

    assign slot_free = !data_busy || S_HREADYOUT;
    assign grant_vld = slot_free && pend_found;
    assign next_ptr  = (grant_idx == IW'(MASTERS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        grant_addr  = slot_addr[0];
        grant_write = slot_write[0];
        grant_size  = slot_size[0];
        S_HWDATA    = M_HWDATA[31:0];
        for (int n = 0; n < MASTERS; n++) begin
            if (grant_idx == IW'(n)) begin
                grant_addr  = slot_addr[n];
                grant_write = slot_write[n];
                grant_size  = slot_size[n];
            end
            if (data_owner == IW'(n)) begin
                S_HWDATA = M_HWDATA[32*n +: 32];
            end
        end
    end

    assign S_HSEL   = grant_vld;
    assign S_HTRANS = grant_vld ? 2'b10 : 2'b00;
    assign S_HADDR  = grant_vld ? grant_addr  : last_addr;
    assign S_HWRITE = grant_vld ? grant_write : last_write;
    assign S_HSIZE  = grant_vld ? grant_size  : last_size;
    assign S_HREADY = data_busy ? S_HREADYOUT : 1'b1;
    assign M_HRDATA = S_HRDATA;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            rr_ptr     <= '0;
            data_owner <= '0;
            data_busy  <= 1'b0;
            last_addr  <= '0;
            last_write <= 1'b0;
            last_size  <= '0;
            for (int n = 0; n < MASTERS; n++) begin
                slot_st[n]    <= SLOT_IDLE;
                slot_addr[n]  <= '0;
                slot_write[n] <= 1'b0;
                slot_size[n]  <= '0;
            end
        end else begin
            if (data_busy && S_HREADYOUT) begin
                data_busy <= 1'b0;
            end
            if (grant_vld) begin
                data_busy  <= 1'b1;
                data_owner <= grant_idx;
                rr_ptr     <= next_ptr;
                last_addr  <= grant_addr;
                last_write <= grant_write;
                last_size  <= grant_size;
            end
            // A completing owner may re-request in the same cycle; capture wins over retire
            for (int n = 0; n < MASTERS; n++) begin
                if (req_vld[n]) begin
                    slot_st[n]    <= SLOT_PEND;
                    slot_addr[n]  <= M_HADDR[32*n +: 32];
                    slot_write[n] <= M_HWRITE[n];
                    slot_size[n]  <= M_HSIZE[3*n +: 3];
                end else if (grant_vld && (grant_idx == IW'(n))) begin
                    slot_st[n] <= SLOT_DATA;
                end else if ((slot_st[n] == SLOT_DATA) && S_HREADYOUT) begin
                    slot_st[n] <= SLOT_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire
